dmem_port: RTL and testbench
============================

// Module: dmem_port
// PURPOSE
//  Data-memory bridge directly downstream of the 54-instruction CPU core.
//  Turns the core's DM_CS/DM_W/DM_R/Bit_S request into accesses on a synchronous single-port word SRAM
//  (1-cycle read latency).
//  Stores: performs sub-word read-modify-write.
//  Loads: aligns the selected byte/half to bits [31:24]/[31:16] so the core's sign/zero extension works unchanged.
//  Stalls the core via busy while a multi-cycle access is in flight.
// PARAMETERS
//  ADDR_W     11             word-address width of the SRAM (2^ADDR_W words)
//  BASE_ADDR  32'h1001_0000  byte address mapped to SRAM word 0; subtracted before indexing
// PORTS
//  clk        in   1       core clock; all state on rising edge
//  rst        in   1       asynchronous, active-high reset
//  cs         in   1       access request (core DM_CS)
//  we         in   1       store when 1 (core DM_W)
//  re         in   1       load when 1 (core DM_R); we&re never both 1
//  size       in   2       0=byte 1=half 2=word (core Bit_S); 3 treated as word
//  addr       in   32      byte address (core ALU result)
//  wdata      in   32      store data, sub-word in LSBs (core Rt)
//  rdata      out  32      load data to core; byte in [31:24], half in [31:16], rest zero
//  busy       out  1       hold PC/regfile write; core keeps cs/addr/wdata stable while high
//  misalign   out  1       1-cycle pulse: half with addr[0]=1 or word with addr[1:0]!=0
//  ram_addr   out  ADDR_W  SRAM word address
//  ram_we     out  1       SRAM write strobe
//  ram_be     out  4       byte enables, bit3=lane[31:24]
//                          (only with macro; else tied 4'hF)
//  ram_wdata  out  32      SRAM write data
//  ram_rdata  in   32      SRAM read data, valid cycle after ram_addr presented
// BEHAVIOUR
//  Reset (async): state=IDLE; busy=0, misalign=0, ram_we=0, rdata=0, ram_addr=0, ram_wdata=0, ram_be=4'hF.
//  Big-endian lanes: addr[1:0]=0 -> [31:24], 1 -> [23:16], 2 -> [15:8], 3 -> [7:0].
//    Half: addr[1]=0 -> [31:16], 1 -> [15:0].
//  word = (addr-BASE_ADDR)[ADDR_W+1:2]; wrap modulo 2^ADDR_W, no fault.
//  FSM IDLE/LOAD/RMW_RD/RMW_WR:
//    IDLE, cs&we&size=word:
//      ram_we=1 combinationally same cycle; busy=0; stay IDLE (single-cycle store).
//    IDLE, cs&re:
//      drive ram_addr, busy=1 -> LOAD.
//    LOAD:
//      register aligned ram_rdata into rdata, busy=0 -> IDLE.
//      rdata valid from the cycle after LOAD; held until next load.
//    IDLE, cs&we&size!=word:
//      busy=1 -> RMW_RD.
//    RMW_RD:
//      capture ram_rdata, merge wdata lane(s) -> RMW_WR.
//    RMW_WR:
//      ram_we=1 with merged word, busy=0 -> IDLE.
//      Total 3 cycles, busy high 2.
//  Misaligned: addr low bits forced to alignment (word: [1:0]=0; half: [0]=0); misalign pulses with the request.
//    Access still performed.
//  cs low in IDLE: no SRAM write, state holds; cs ignored outside IDLE (core is stalled).
//  Reset mid-RMW: write aborted, SRAM word untouched, IDLE next.
//  Back-to-back: new request accepted in the cycle after busy falls; no request lost or duplicated.
// CONFIGURATION
//  DMEM_BYTE_ENABLE_EN defined:
//    ram_be drives lane enables; sub-word stores are single-cycle like word stores.
//    RMW_RD/RMW_WR unused; wdata replicated to all lanes.
//  Undefined:
//    ram_be=4'hF constant; sub-word stores use 3-cycle RMW above.
//  Load path identical in both.
// STRUCTURE
//  Package dmem_pkg:
//    SIZE_BYTE/SIZE_HALF/SIZE_WORD constants, dmem_state_t enum, DMEM_BASE_DEFAULT.
//  Sub-module dmem_lane_align (combinational):
//    load extract/shift-to-MSB;
//    store merge/replicate;
//    be generation; shared by both configs.
// TESTING
//  1 sw 0xDEADBEEF @0x1001_0004, then lw same -> ram_we one cycle; rdata=0xDEADBEEF, busy high 1 cycle on load.
//  2 Word=0x11223344; sb 0xAA @+2 -> word 0x1122AA44.
//    Without macro: busy 2 cycles, ram_we once. With macro: ram_be=4'b0010, busy 0.
//  3 Word=0x8081_7F7E: lb @+0 -> rdata[31:24]=0x80; lh @+2 -> rdata[31:16]=0x7F7E; lower bits 0.
//  4 sh @0x1001_0003 -> misalign pulse 1 cycle; write lands in lanes [15:0] of word 0.
//  5 Assert rst during RMW_RD of sb -> busy=0 immediately, SRAM word unchanged, next lw returns old value.
//  6 addr=BASE+4*2^ADDR_W -> ram_addr=0 (wrap); back-to-back sb,sb,lw -> both bytes visible, no lost write.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the dmem_port data-memory bridge.
//   SIZE_*            access size codes as issued by the core (3 folds onto word)
//   dmem_state_t      bridge FSM states
//   DMEM_BASE_DEFAULT byte address that maps onto SRAM word 0
package dmem_pkg;

  localparam logic [1:0]  SIZE_BYTE = 2'd0;
  localparam logic [1:0]  SIZE_HALF = 2'd1;
  localparam logic [1:0]  SIZE_WORD = 2'd2;

  localparam logic [31:0] DMEM_BASE_DEFAULT = 32'h1001_0000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_RMW_RD = 2'd2,
    ST_RMW_WR = 2'd3
  } dmem_state_t;

  // The core's encoding 3 behaves exactly like a word access.
  function automatic logic [1:0] norm_size(input logic [1:0] sz);
    return (sz == 2'd3) ? SIZE_WORD : sz;
  endfunction

  // Misaligned addresses are rounded down to the natural alignment of the size.
  function automatic logic [1:0] align_lo(input logic [1:0] sz, input logic [1:0] lo);
    case (sz)
      SIZE_WORD: return 2'b00;
      SIZE_HALF: return {lo[1], 1'b0};
      default:   return lo;
    endcase
  endfunction

endpackage

// File: rtl/dmem_port_if.sv
// dmem_port_if: core-side request/response bundle of the data-memory bridge.
//   cs/we/re/size/addr/wdata  request from the core (master drives)
//   rdata                     MSB-aligned load data back to the core
//   busy                      stall while a multi-cycle access is in flight
//   misalign                  one-cycle pulse on a misaligned half/word request
interface dmem_port_if;
  logic        cs;
  logic        we;
  logic        re;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        busy;
  logic        misalign;

  modport master (output cs, we, re, size, addr, wdata,
                  input  rdata, busy, misalign);
  modport slave  (input  cs, we, re, size, addr, wdata,
                  output rdata, busy, misalign);
endinterface

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational big-endian lane steering.
//   size_i   normalised access size
//   lo_i     aligned byte offset inside the word (0 = lanes [31:24])
//   wdata_i  store data, sub-word in LSBs
//   word_i   SRAM word (load source and RMW merge base)
//   load_o   selected byte/half shifted to the MSBs, remaining bits zero
//   repl_o   store data replicated across all lanes
//   merge_o  word_i with the addressed lane(s) replaced by store data
//   be_o     lane enables, bit3 = [31:24]
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] word_i,
  output logic [31:0] load_o,
  output logic [31:0] repl_o,
  output logic [31:0] merge_o,
  output logic [3:0]  be_o
);

  logic [31:0] shifted;
  logic [31:0] mask;

  // Shifting left by the lane offset brings the addressed lane(s) to the top.
  assign shifted = word_i << {lo_i, 3'b000};

  always_comb begin
    load_o = word_i;
    repl_o = wdata_i;
    be_o   = 4'hF;
    case (size_i)
      SIZE_BYTE: begin
        load_o = {shifted[31:24], 24'h0};
        repl_o = {4{wdata_i[7:0]}};
        be_o   = 4'b1000 >> lo_i;
      end
      SIZE_HALF: begin
        load_o = {shifted[31:16], 16'h0};
        repl_o = {2{wdata_i[15:0]}};
        be_o   = 4'b1100 >> lo_i;
      end
      default: begin
        load_o = word_i;
        repl_o = wdata_i;
        be_o   = 4'hF;
      end
    endcase
  end

  assign mask    = {{8{be_o[3]}}, {8{be_o[2]}}, {8{be_o[1]}}, {8{be_o[0]}}};
  assign merge_o = (word_i & ~mask) | (repl_o & mask);

endmodule

// File: rtl/dmem_port.sv
// dmem_port: bridges core data-memory requests onto a 1-cycle-latency single-port word SRAM.
//   clk, rst      core clock, asynchronous active-high reset
//   bus           dmem_port_if.slave (core request, rdata/busy/misalign back)
//   ram_addr_o    SRAM word address
//   ram_we_o      SRAM write strobe
//   ram_be_o      SRAM lane enables (bit3 = [31:24])
//   ram_wdata_o   SRAM write data
//   ram_rdata_i   SRAM read data, valid the cycle after ram_addr_o
// Build option DMEM_BYTE_ENABLE_EN: sub-word stores become single-cycle lane-enabled
// writes; otherwise ram_be_o is 4'hF and sub-word stores use read-modify-write.
//
//   state     | meaning
//   ST_IDLE   | accept request; word stores complete here
//   ST_LOAD   | SRAM data arriving, latched into rdata
//   ST_RMW_RD | old word arriving, merged with store lane(s)
//   ST_RMW_WR | merged word written back
module dmem_port
  import dmem_pkg::*;
#(
  parameter int          ADDR_W    = 11,
  parameter logic [31:0] BASE_ADDR = DMEM_BASE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  dmem_port_if.slave        bus,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_we_o,
  output logic [3:0]        ram_be_o,
  output logic [31:0]       ram_wdata_o,
  input  logic [31:0]       ram_rdata_i
);

`ifdef DMEM_BYTE_ENABLE_EN
  localparam bit BE_EN = 1'b1;
`else
  localparam bit BE_EN = 1'b0;
`endif

  dmem_state_t       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d, lo_q, lo_d;
  logic [31:0]       wdata_q, wdata_d, rdata_q, rdata_d;

  logic [31:0]       off;
  logic [ADDR_W-1:0] word_idx;
  logic [1:0]        size_n, lo_req, size_sel, lo_sel;
  logic [31:0]       wdata_sel, lane_load, lane_repl, lane_merge;
  logic [3:0]        lane_be;
  logic              req, idle, sub_req, mis_req, take_ld, take_rmw, st_now;
  logic              unused_bits;

  // Gating with rst keeps the combinational SRAM strobes quiet while reset is held.
  assign req      = bus.cs & ~rst;
  assign idle     = (state_q == ST_IDLE);
  assign off      = bus.addr - BASE_ADDR;
  assign word_idx = off[ADDR_W+1:2];
  assign size_n   = norm_size(bus.size);
  assign lo_req   = align_lo(size_n, bus.addr[1:0]);
  assign sub_req  = (size_n != SIZE_WORD);
  assign mis_req  = ((size_n == SIZE_HALF) && bus.addr[0]) ||
                    ((size_n == SIZE_WORD) && (bus.addr[1:0] != 2'b00));

  assign take_ld  = idle && req && bus.re;
  assign take_rmw = idle && req && bus.we && sub_req && !BE_EN;
  assign st_now   = idle && req && bus.we && (!sub_req || BE_EN);

  // In IDLE the lane logic works on the live request, afterwards on the latched one.
  assign size_sel  = idle ? size_n    : size_q;
  assign lo_sel    = idle ? lo_req    : lo_q;
  assign wdata_sel = idle ? bus.wdata : wdata_q;

  dmem_lane_align u_align (
    .size_i  (size_sel),
    .lo_i    (lo_sel),
    .wdata_i (wdata_sel),
    .word_i  (ram_rdata_i),
    .load_o  (lane_load),
    .repl_o  (lane_repl),
    .merge_o (lane_merge),
    .be_o    (lane_be)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (take_ld)       state_d = ST_LOAD;
        else if (take_rmw) state_d = ST_RMW_RD;
      end
      ST_LOAD:   state_d = ST_IDLE;
      ST_RMW_RD: state_d = ST_RMW_WR;
      ST_RMW_WR: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.busy     = take_ld || take_rmw || (state_q == ST_RMW_RD);
    bus.misalign = idle && req && mis_req;
    ram_we_o     = st_now || (state_q == ST_RMW_WR);
    ram_addr_o   = (idle && req) ? word_idx : addr_q;
    ram_wdata_o  = st_now ? lane_repl : wdata_q;
  end

`ifdef DMEM_BYTE_ENABLE_EN
  assign ram_be_o = st_now ? lane_be : 4'hF;
`else
  assign ram_be_o = 4'hF;
`endif

  assign bus.rdata   = rdata_q;
  assign unused_bits = ^{off[31:ADDR_W+2], off[1:0], lane_be};

  always_comb begin
    addr_d  = addr_q;
    size_d  = size_q;
    lo_d    = lo_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    if (take_ld || take_rmw) begin
      addr_d  = word_idx;
      size_d  = size_n;
      lo_d    = lo_req;
      wdata_d = bus.wdata;
    end
    if (state_q == ST_LOAD)   rdata_d = lane_load;
    if (state_q == ST_RMW_RD) wdata_d = lane_merge;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      size_q  <= SIZE_WORD;
      lo_q    <= 2'b00;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      addr_q  <= addr_d;
      size_q  <= size_d;
      lo_q    <= lo_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_port.sv
module tb_dmem_port;
  import dmem_pkg::*;

  localparam int          ADDR_W = 11;
  localparam int          NW     = 1 << ADDR_W;
  localparam logic [31:0] BASE   = 32'h1001_0000;
`ifdef DMEM_BYTE_ENABLE_EN
  localparam bit BE = 1'b1;
`else
  localparam bit BE = 1'b0;
`endif

  logic              clk, rst;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [3:0]        ram_be;
  logic [31:0]       ram_wdata, ram_rdata;
  logic [31:0]       sram    [NW];
  logic [31:0]       ref_mem [NW];
  logic [31:0]       last_rd;
  int                n_chk, n_pass;

  dmem_port_if bus ();

  dmem_port #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .ram_addr_o  (ram_addr),
    .ram_we_o    (ram_we),
    .ram_be_o    (ram_be),
    .ram_wdata_o (ram_wdata),
    .ram_rdata_i (ram_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (ram_we)
      for (int b = 0; b < 4; b++)
        if (ram_be[b]) sram[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    ram_rdata <= sram[ram_addr];
  end

  // Reference model: byte-oriented big-endian memory.
  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic int widx(input logic [31:0] a);
    logic [31:0] o;
    o = (a - BASE) >> 2;
    return int'(o) & (NW - 1);
  endfunction

  function automatic int first_lane(input logic [31:0] a, input logic [1:0] sz);
    int lo;
    lo = int'(a[1:0]);
    return lo - (lo % nbytes(sz));
  endfunction

  function automatic logic [31:0] exp_be(input logic [31:0] a, input logic [1:0] sz);
    logic [31:0] e;
    e = '0;
    for (int k = 0; k < nbytes(sz); k++) e[3 - (first_lane(a, sz) + k)] = 1'b1;
    return e;
  endfunction

  function automatic logic [31:0] exp_mis(input logic [31:0] a, input logic [1:0] sz);
    int n;
    n = nbytes(sz);
    return ((n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00)) ? 32'd1 : 32'd0;
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    int n, l0, idx;
    logic [31:0] w;
    n = nbytes(sz); l0 = first_lane(a, sz); idx = widx(a);
    w = ref_mem[idx];
    for (int k = 0; k < n; k++) w[8*(3 - (l0 + k)) +: 8] = d[8*(n - 1 - k) +: 8];
    ref_mem[idx] = w;
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz);
    int n, l0, idx;
    logic [31:0] v;
    n = nbytes(sz); l0 = first_lane(a, sz); idx = widx(a);
    v = '0;
    for (int k = 0; k < n; k++) v = (v << 8) | {24'h0, ref_mem[idx][8*(3 - (l0 + k)) +: 8]};
    return v << (8 * (4 - n));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Core-like master: hold the request until a cycle with busy low has been clocked.
  task automatic access(input logic w, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] d, output int bc, output int wc, output int mc,
                        output logic [3:0] bs, output logic [ADDR_W-1:0] ra0, output logic dn);
    logic b;
    bus.cs = 1'b1; bus.we = w; bus.re = !w; bus.size = sz; bus.addr = a; bus.wdata = d;
    bc = 0; wc = 0; mc = 0; bs = 4'hF; ra0 = '0; dn = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (k == 0) ra0 = ram_addr;
      if (bus.busy) bc++;
      if (ram_we) begin wc++; bs = ram_be; end
      if (bus.misalign) mc++;
      b = bus.busy;
      @(posedge clk); #1;
      if (!b) begin dn = 1'b1; break; end
    end
    bus.cs = 1'b0; bus.we = 1'b0; bus.re = 1'b0;
  endtask

  task automatic do_op(input logic w, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] d, output logic [31:0] rd, output logic [ADDR_W-1:0] ra0);
    int bc, wc, mc, n;
    logic [3:0] bs;
    logic dn;
    access(w, sz, a, d, bc, wc, mc, bs, ra0, dn);
    n = nbytes(sz);
    chk("done", 32'(dn), 32'd1);
    chk("busy_cycles", 32'(bc), w ? ((n != 4 && !BE) ? 32'd2 : 32'd0) : 32'd1);
    chk("we_cycles", 32'(wc), w ? 32'd1 : 32'd0);
    chk("misalign", 32'(mc), exp_mis(a, sz));
    chk("ram_addr", 32'(ra0), 32'(widx(a)));
    chk("ram_be", 32'(bs), (w && BE) ? exp_be(a, sz) : 32'hF);
    if (w) begin
      ref_store(a, d, sz);
      chk("sram_word", sram[widx(a)], ref_mem[widx(a)]);
    end else begin
      last_rd = ref_load(a, sz);
    end
    rd = bus.rdata;
    chk("rdata", rd, last_rd);
  endtask

  initial begin
    logic [31:0]       rd, a, d;
    logic [ADDR_W-1:0] ra;
    logic [1:0]        sz;
    logic              w;
    n_chk = 0; n_pass = 0; last_rd = '0;
    bus.cs = 1'b0; bus.we = 1'b0; bus.re = 1'b0; bus.size = 2'd0;
    bus.addr = '0; bus.wdata = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_misalign", 32'(bus.misalign), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_ram_wdata", ram_wdata, 32'd0);
    chk("rst_ram_be", 32'(ram_be), 32'hF);
    rst = 1'b0;
    @(posedge clk); #1;

    // idle with we high but cs low: nothing happens
    bus.we = 1'b1; bus.size = SIZE_WORD; bus.addr = BASE;
    #1;
    chk("idle_we", 32'(ram_we), 32'd0);
    chk("idle_busy", 32'(bus.busy), 32'd0);
    bus.we = 1'b0;
    @(posedge clk); #1;

    // 1: word store then load
    do_op(1'b1, SIZE_WORD, BASE + 4, 32'hDEADBEEF, rd, ra);
    do_op(1'b0, SIZE_WORD, BASE + 4, 32'h0, rd, ra);
    chk("t1_lw", rd, 32'hDEADBEEF);

    // 2: byte store into the middle of a word
    do_op(1'b1, SIZE_WORD, BASE + 8, 32'h11223344, rd, ra);
    do_op(1'b1, SIZE_BYTE, BASE + 10, 32'h000000AA, rd, ra);
    do_op(1'b0, SIZE_WORD, BASE + 8, 32'h0, rd, ra);
    chk("t2_lw", rd, 32'h1122AA44);

    // 3: sub-word loads land in the MSBs
    do_op(1'b1, SIZE_WORD, BASE + 12, 32'h80817F7E, rd, ra);
    do_op(1'b0, SIZE_BYTE, BASE + 12, 32'h0, rd, ra);
    chk("t3_lb", rd, 32'h80000000);
    do_op(1'b0, SIZE_HALF, BASE + 14, 32'h0, rd, ra);
    chk("t3_lh", rd, 32'h7F7E0000);

    // 4: misaligned half store is rounded down to lanes [15:0]
    do_op(1'b1, SIZE_WORD, BASE, 32'h01020304, rd, ra);
    do_op(1'b1, SIZE_HALF, BASE + 3, 32'h0000BEEF, rd, ra);
    do_op(1'b0, SIZE_WORD, BASE, 32'h0, rd, ra);
    chk("t4_lw", rd, 32'h0102BEEF);

    // 5: reset in the middle of a byte store
    do_op(1'b1, SIZE_WORD, BASE + 24, 32'hCAFEF00D, rd, ra);
    bus.cs = 1'b1; bus.we = 1'b1; bus.re = 1'b0; bus.size = SIZE_BYTE;
    bus.addr = BASE + 25; bus.wdata = 32'h00000055;
    #1;
    chk("t5_busy_req", 32'(bus.busy), BE ? 32'd0 : 32'd1);
    @(posedge clk); #1;
    if (BE) ref_store(BASE + 25, 32'h55, SIZE_BYTE);
    rst = 1'b1;
    #1;
    chk("t5_busy_rst", 32'(bus.busy), 32'd0);
    chk("t5_we_rst", 32'(ram_we), 32'd0);
    @(posedge clk); #1;
    bus.cs = 1'b0; bus.we = 1'b0; rst = 1'b0;
    last_rd = '0;
    @(posedge clk); #1;
    chk("t5_rdata_rst", bus.rdata, 32'd0);
    chk("t5_sram", sram[6], ref_mem[6]);
    do_op(1'b0, SIZE_WORD, BASE + 24, 32'h0, rd, ra);
    chk("t5_lw", rd, BE ? 32'hCA55F00D : 32'hCAFEF00D);

    // 6: address wrap and back-to-back stores
    do_op(1'b0, SIZE_WORD, BASE + 4 * NW, 32'h0, rd, ra);
    chk("t6_wrap_addr", 32'(ra), 32'd0);
    chk("t6_wrap_data", rd, 32'h0102BEEF);
    do_op(1'b1, SIZE_WORD, BASE + 20, 32'h0, rd, ra);
    do_op(1'b1, SIZE_BYTE, BASE + 20, 32'h11, rd, ra);
    do_op(1'b1, SIZE_BYTE, BASE + 23, 32'h22, rd, ra);
    do_op(1'b0, SIZE_WORD, BASE + 20, 32'h0, rd, ra);
    chk("t6_b2b", rd, 32'h11000022);

    // random traffic over a small window, initialised first
    for (int i = 0; i < 16; i++) do_op(1'b1, SIZE_WORD, BASE + 32'(4 * i), $urandom, rd, ra);
    for (int i = 0; i < 200; i++) begin
      w  = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      a  = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = a + 32'(4 * NW);
      d  = $urandom;
      do_op(w, sz, a, d, rd, ra);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
